// File: rtl/fpm_sched_pkg.sv
// ============================================================================
//  Module   : fpm_sched_pkg
//  Purpose  : Shared constants and helpers for the half-precision multiplier
//             issue scheduler: IEEE half field layout, exception-flag bit
//             positions and the exception decode used at result capture.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package fpm_sched_pkg;

    localparam int HALF_W   = 16;
    localparam int EXP_W    = 5;
    localparam int MAN_W    = 10;

    // Exception flags are ordered {NaN, Inf, Zero}
    localparam int EXC_W    = 3;
    localparam int EXC_NAN  = 2;
    localparam int EXC_INF  = 1;
    localparam int EXC_ZERO = 0;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fpm_half_t;

    function automatic logic [EXC_W-1:0] fpm_exc_decode(input logic [HALF_W-1:0] v);
        fpm_half_t        h;
        logic [EXC_W-1:0] f;
        h           = v;
        f           = '0;
        f[EXC_NAN]  = (&h.exp) && (h.man != '0);
        f[EXC_INF]  = (&h.exp) && (h.man == '0);
        f[EXC_ZERO] = ({h.exp, h.man} == '0);
        return f;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fpm_result_fifo.sv
// ============================================================================
//  Module   : fpm_result_fifo
//  Purpose  : Synchronous first-word-fall-through FIFO with occupancy count
//             and a synchronous clear.
//  Ports    : clk, rst_n (async active-low)
//             clr_i            discard all entries at next edge
//             push_i/wdata_i   write one entry
//             pop_i            consume head (ignored when empty)
//             valid_o/rdata_o  head entry, visible without a read strobe
//             count_o          number of stored entries
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fpm_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 22,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push_i && (cnt_q != CNT_W'(DEPTH));
    assign do_pop  = pop_i && (cnt_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign valid_o = (cnt_q != '0);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/fpm_issue_arbiter.sv
// ============================================================================
//  Module   : fpm_issue_arbiter
//  Purpose  : Round-robin issue of NUM_REQ requesters onto one fixed-latency
//             half-precision multiplier, tag/source tracking through the
//             multiplier pipe, credit-protected FWFT result FIFO.
//  Ports    : clk, rst_n (async active-low), flush
//             req_valid/req_a/req_b/req_tag in, req_ready out (one-hot grant)
//             mul_a/mul_b out (registered operands), mul_p in (product)
//             res_valid/res_ready/res_data/res_tag/res_src result bus
//             res_exc {NaN,Inf,Zero} when FPM_EXC_FLAGS_EN is defined
//             busy  any op in flight or queued
//  Config   : `define FPM_EXC_FLAGS_EN adds res_exc and per-entry flags
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fpm_issue_arbiter
    import fpm_sched_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int TAG_W     = 4,
    parameter int MUL_LAT   = 3,
    parameter int OUT_DEPTH = 4,
    parameter int SRC_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*16-1:0]    req_a,
    input  logic [NUM_REQ*16-1:0]    req_b,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [15:0]              mul_a,
    output logic [15:0]              mul_b,
    input  logic [15:0]              mul_p,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [15:0]              res_data,
    output logic [TAG_W-1:0]         res_tag,
    output logic [SRC_W-1:0]         res_src,
`ifdef FPM_EXC_FLAGS_EN
    output logic [2:0]               res_exc,
`endif
    output logic                     busy
);

    localparam int CNT_W = $clog2(OUT_DEPTH + 1);
    // Stage 0 runs alongside mul_a/mul_b; the tail lines up with mul_p.
    localparam int TRK_N = MUL_LAT + 1;
`ifdef FPM_EXC_FLAGS_EN
    localparam int ENT_W = HALF_W + TAG_W + SRC_W + EXC_W;
`else
    localparam int ENT_W = HALF_W + TAG_W + SRC_W;
`endif

    logic [SRC_W-1:0] ptr_q, ptr_d;
    logic [15:0]      mul_a_q, mul_b_q;
    logic [TRK_N-1:0] trk_vld_q;
    logic [TAG_W-1:0] trk_tag_q [TRK_N];
    logic [SRC_W-1:0] trk_src_q [TRK_N];
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] fifo_cnt;
    logic [CNT_W:0]   outstanding;
    logic             grant_en;
    logic             found;
    logic [SRC_W-1:0] gnt_idx;
    logic [SRC_W-1:0] scan_idx;
    logic             accept;
    logic             capture;
    logic             pop;
    logic [15:0]      sel_a, sel_b;
    logic [TAG_W-1:0] sel_tag;
    logic [ENT_W-1:0] fifo_wdata;
    logic [ENT_W-1:0] fifo_rdata;

    // A pop in the current cycle frees its slot before the op just issued can
    // reach the FIFO (MUL_LAT+1 edges later), so it may be spent immediately.
    assign pop         = res_valid & res_ready;
    assign outstanding = {1'b0, inflight_q} + {1'b0, fifo_cnt} - (CNT_W + 1)'(pop);
    assign grant_en    = rst_n & ~flush & (outstanding < (CNT_W + 1)'(OUT_DEPTH));

    // Round-robin scan starting one past the last granted requester
    always_comb begin
        found    = 1'b0;
        gnt_idx  = ptr_q;
        scan_idx = ptr_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = SRC_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && req_valid[scan_idx]) begin
                found   = 1'b1;
                gnt_idx = scan_idx;
            end
        end
        req_ready = (found && grant_en) ? (NUM_REQ'(1) << gnt_idx) : '0;
    end

    assign accept  = |(req_valid & req_ready);
    assign sel_a   = req_a[16*gnt_idx +: 16];
    assign sel_b   = req_b[16*gnt_idx +: 16];
    assign sel_tag = req_tag[TAG_W*gnt_idx +: TAG_W];
    assign ptr_d   = accept ? gnt_idx : ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= SRC_W'(NUM_REQ - 1);
            mul_a_q <= '0;
            mul_b_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (accept) begin
                mul_a_q <= sel_a;
                mul_b_q <= sel_b;
            end
        end
    end

    // Tag/source tracking; only the valid bits matter for flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_vld_q <= '0;
            for (int i = 0; i < TRK_N; i++) begin
                trk_tag_q[i] <= '0;
                trk_src_q[i] <= '0;
            end
        end else begin
            trk_vld_q    <= flush ? '0 : {trk_vld_q[TRK_N-2:0], accept};
            trk_tag_q[0] <= sel_tag;
            trk_src_q[0] <= gnt_idx;
            for (int i = 1; i < TRK_N; i++) begin
                trk_tag_q[i] <= trk_tag_q[i-1];
                trk_src_q[i] <= trk_src_q[i-1];
            end
        end
    end

    assign capture    = trk_vld_q[TRK_N-1];
    assign inflight_d = flush ? '0 : inflight_q + CNT_W'(accept) - CNT_W'(capture);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) inflight_q <= '0;
        else        inflight_q <= inflight_d;
    end

`ifdef FPM_EXC_FLAGS_EN
    assign fifo_wdata = {mul_p, trk_tag_q[TRK_N-1], trk_src_q[TRK_N-1], fpm_exc_decode(mul_p)};
`else
    assign fifo_wdata = {mul_p, trk_tag_q[TRK_N-1], trk_src_q[TRK_N-1]};
`endif

    fpm_result_fifo #(
        .DEPTH (OUT_DEPTH),
        .WIDTH (ENT_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (flush),
        .push_i  (capture),
        .wdata_i (fifo_wdata),
        .pop_i   (pop),
        .valid_o (res_valid),
        .rdata_o (fifo_rdata),
        .count_o (fifo_cnt)
    );

`ifdef FPM_EXC_FLAGS_EN
    assign {res_data, res_tag, res_src, res_exc} = fifo_rdata;
`else
    assign {res_data, res_tag, res_src} = fifo_rdata;
`endif

    assign mul_a = mul_a_q;
    assign mul_b = mul_b_q;
    assign busy  = (inflight_q != '0) | (fifo_cnt != '0);

endmodule

`default_nettype wire

// File: tb/tb_fpm_issue_arbiter.sv
// ============================================================================
//  Module   : tb_fpm_issue_arbiter
//  Purpose  : Directed self-checking bench for fpm_issue_arbiter with an
//             ideal-delay-line half-precision multiplier model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fpm_issue_arbiter;

    localparam int N   = 4;
    localparam int TW  = 4;
    localparam int LAT = 3;
    localparam int DEP = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic [N-1:0]      req_valid;
    logic [N*16-1:0]   req_a;
    logic [N*16-1:0]   req_b;
    logic [N*TW-1:0]   req_tag;
    logic [N-1:0]      req_ready;
    logic [15:0]       mul_a, mul_b, mul_p;
    logic              res_valid;
    logic              res_ready;
    logic [15:0]       res_data;
    logic [TW-1:0]     res_tag;
    logic [1:0]        res_src;
    logic              busy;
`ifdef FPM_EXC_FLAGS_EN
    logic [2:0]        res_exc;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] b_tab  [4] = '{16'h4000, 16'h4200, 16'h4400, 16'h4500};
    logic [15:0] p_tab  [4] = '{16'h4400, 16'h4600, 16'h4800, 16'h4900};
    int          rr_exp [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
    int          bp_exp [5] = '{1, 2, 3, 0, 1};

    fpm_issue_arbiter #(
        .NUM_REQ(N), .TAG_W(TW), .MUL_LAT(LAT), .OUT_DEPTH(DEP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .req_ready(req_ready),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_tag(res_tag), .res_src(res_src),
`ifdef FPM_EXC_FLAGS_EN
        .res_exc(res_exc),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference half-precision multiply, exact for the normal operands used here
    function automatic logic [15:0] fpm_model(input logic [15:0] a, input logic [15:0] b);
        logic        s;
        logic [4:0]  ea, eb;
        logic [9:0]  ma, mb;
        logic [21:0] p;
        int          e;
        s = a[15] ^ b[15];
        ea = a[14:10]; eb = b[14:10];
        ma = a[9:0];   mb = b[9:0];
        if ((ea == 5'h1F && ma != 0) || (eb == 5'h1F && mb != 0)) return 16'h7E00;
        if (ea == 5'h1F || eb == 5'h1F) begin
            if (a[14:0] == 0 || b[14:0] == 0) return 16'h7E00;
            return {s, 5'h1F, 10'h000};
        end
        if (ea == 0 || eb == 0) return {s, 15'h0000};
        p = 22'({1'b1, ma}) * 22'({1'b1, mb});
        e = int'(ea) + int'(eb) - 15;
        if (p[21]) return {s, 5'(e + 1), p[20:11]};
        return {s, 5'(e), p[19:10]};
    endfunction

    logic [15:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= fpm_model(mul_a, mul_b);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mul_p = pipe[LAT-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic load_all_ops();
        for (int i = 0; i < N; i++) begin
            req_a[16*i +: 16]   = 16'h4000;
            req_b[16*i +: 16]   = b_tab[i];
            req_tag[TW*i +: TW] = TW'(8 + i);
        end
    endtask

    task automatic run_single(input string nm, input logic [15:0] a, input logic [15:0] b,
                              input logic [3:0] tag, input logic [15:0] exp_p,
                              input logic [2:0] exp_exc);
        req_valid    = 4'b0001;
        req_a[15:0]  = a;
        req_b[15:0]  = b;
        req_tag[3:0] = tag;
        #1;
        check({nm, "_grant"}, 32'(req_ready), 32'h1);
        next_cycle();
        req_valid = '0;
        check({nm, "_mul_a"}, 32'(mul_a), 32'(a));
        for (int j = 1; j <= LAT; j++) begin
            next_cycle();
            check($sformatf("%s_early%0d", nm, j), 32'(res_valid), 32'h0);
        end
        next_cycle();
        check({nm, "_valid"}, 32'(res_valid), 32'h1);
        check({nm, "_data"},  32'(res_data),  32'(exp_p));
        check({nm, "_tag"},   32'(res_tag),   32'(tag));
        check({nm, "_src"},   32'(res_src),   32'h0);
`ifdef FPM_EXC_FLAGS_EN
        check({nm, "_exc"},   32'(res_exc),   32'(exp_exc));
`else
        if (exp_exc === 3'bxxx) $display("unexpected flag argument");
`endif
        res_ready = 1'b1;
        next_cycle();
        res_ready = 1'b0;
        check({nm, "_drained"}, 32'(res_valid), 32'h0);
        check({nm, "_idle"},    32'(busy),      32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, r, cnt;
        rst_n     = 1'b0;
        flush     = 1'b0;
        req_valid = 4'b1111;
        req_a     = '0;
        req_b     = '0;
        req_tag   = '0;
        res_ready = 1'b0;
        #12;
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_mul_a",     32'(mul_a),     32'h0);
        check("rst_res_valid", 32'(res_valid), 32'h0);
        check("rst_res_data",  32'(res_data),  32'h0);
        check("rst_busy",      32'(busy),      32'h0);
        req_valid = '0;
        #10 rst_n = 1'b1;
        next_cycle();

        // 1.0 * 2.0
        run_single("single", 16'h3C00, 16'h4000, 4'd5, 16'h4000, 3'b000);

        // Round robin with free-flowing results; pointer now at 0
        load_all_ops();
        res_ready = 1'b1;
        req_valid = 4'b1111;
        g = 0; r = 0;
        for (int c = 0; c < 60 && r < 8; c++) begin
            #1;
            if (g < 8 && req_ready != 0) begin
                check($sformatf("rr_grant%0d", g), 32'(req_ready), 32'(1 << rr_exp[g]));
                g++;
            end
            if (res_valid) begin
                check($sformatf("rr_data%0d", r), 32'(res_data), 32'(p_tab[rr_exp[r]]));
                check($sformatf("rr_tag%0d", r),  32'(res_tag),  32'(8 + rr_exp[r]));
                check($sformatf("rr_src%0d", r),  32'(res_src),  32'(rr_exp[r]));
                r++;
            end
            next_cycle();
            if (g >= 8) req_valid = '0;
        end
        check("rr_results", 32'(r), 32'd8);
        req_valid = '0;

        // Backpressure: credits cap outstanding ops at the FIFO depth
        res_ready = 1'b0;
        req_valid = 4'b1111;
        g = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (req_ready != 0) begin
                if (g < 4) check($sformatf("bp_grant%0d", g), 32'(req_ready), 32'(1 << bp_exp[g]));
                g++;
            end
            next_cycle();
        end
        check("bp_accepts", 32'(g), 32'd4);
        #1;
        check("bp_stalled",   32'(req_ready), 32'h0);
        check("bp_head_vld",  32'(res_valid), 32'h1);
        check("bp_head_src",  32'(res_src),   32'(bp_exp[0]));
        check("bp_head_data", 32'(res_data),  32'(p_tab[bp_exp[0]]));
        res_ready = 1'b1;
        #1;
        check("bp_resume", 32'(req_ready), 32'(1 << bp_exp[4]));
        next_cycle();
        req_valid = '0;
        r = 1;
        for (int c = 0; c < 20 && r < 5; c++) begin
            #1;
            if (res_valid) begin
                check($sformatf("bp_src%0d", r),  32'(res_src),  32'(bp_exp[r]));
                check($sformatf("bp_data%0d", r), 32'(res_data), 32'(p_tab[bp_exp[r]]));
                r++;
            end
            next_cycle();
        end
        check("bp_results", 32'(r), 32'd5);
        check("bp_idle",    32'(busy), 32'h0);

        // Flush with three ops in flight; pointer now at 1 -> grants 2,3,0
        req_valid = 4'b1111;
        repeat (3) next_cycle();
        flush = 1'b1;
        #1;
        check("flush_nogrant", 32'(req_ready), 32'h0);
        next_cycle();
        flush     = 1'b0;
        req_valid = '0;
        check("flush_busy",  32'(busy),      32'h0);
        check("flush_valid", 32'(res_valid), 32'h0);
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (res_valid) cnt++;
            next_cycle();
        end
        check("flush_no_result", 32'(cnt), 32'd0);
        req_valid = 4'b1111;
        #1;
        check("flush_ptr_kept", 32'(req_ready), 32'h2);

        // Asynchronous reset in the middle of a stalled burst
        res_ready = 1'b0;
        repeat (8) next_cycle();
        #1;
        check("pre_rst_valid", 32'(res_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        check("arst_req_ready", 32'(req_ready), 32'h0);
        check("arst_mul_a",     32'(mul_a),     32'h0);
        check("arst_mul_b",     32'(mul_b),     32'h0);
        check("arst_res_valid", 32'(res_valid), 32'h0);
        check("arst_res_data",  32'(res_data),  32'h0);
        check("arst_busy",      32'(busy),      32'h0);
        #2 rst_n = 1'b1;
        #1;
        check("arst_req0_first", 32'(req_ready), 32'h1);
        next_cycle();
        req_valid = '0;
        res_ready = 1'b1;
        repeat (8) next_cycle();
        res_ready = 1'b0;
        check("arst_drained", 32'(busy), 32'h0);

`ifdef FPM_EXC_FLAGS_EN
        run_single("exc_nan", 16'h7C00, 16'h0000, 4'd1, 16'h7E00, 3'b100);
        run_single("exc_inf", 16'h7C00, 16'h3C00, 4'd2, 16'h7C00, 3'b010);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
